// File: rtl/mips_boot_pkg.sv
// mips_boot_pkg: shared state encoding and default sizes for the boot controller
package mips_boot_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 6;
    localparam int REG_AW   = 5;
    localparam int HOLD_CYC = 2;
    localparam int CNT_W    = 32;
    typedef enum logic [2:0] {CLEAR, LOAD, HOLD, RUN, DUMP} state_t;
endpackage

// File: rtl/mips_boot_ctrl_if.sv
// mips_boot_ctrl_if: load stream, memory/register-file write ports, cpu control and dump stream
// master = controller side, slave = environment side (loader, memories, core, dump sink)
interface mips_boot_ctrl_if #(
    parameter int DATA_W = mips_boot_pkg::DATA_W,
    parameter int ADDR_W = mips_boot_pkg::ADDR_W,
    parameter int REG_AW = mips_boot_pkg::REG_AW,
    parameter int CNT_W  = mips_boot_pkg::CNT_W
);
    logic              ld_valid, ld_ready, ld_last;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              rf_we;
    logic [REG_AW-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata, rf_rdata;
    logic              cpu_rst, cpu_stall;
    logic              dump_req, dump_valid, dump_ready;
    logic [REG_AW-1:0] dump_idx;
    logic [DATA_W-1:0] dump_data;
    logic [CNT_W-1:0]  cycle_cnt;
    modport master (
        input  ld_valid, ld_addr, ld_data, ld_last, rf_rdata, dump_req, dump_ready,
        output ld_ready, mem_we, mem_addr, mem_wdata, rf_we, rf_addr, rf_wdata,
               cpu_rst, cpu_stall, dump_valid, dump_idx, dump_data, cycle_cnt
    );
    modport slave (
        output ld_valid, ld_addr, ld_data, ld_last, rf_rdata, dump_req, dump_ready,
        input  ld_ready, mem_we, mem_addr, mem_wdata, rf_we, rf_addr, rf_wdata,
               cpu_rst, cpu_stall, dump_valid, dump_idx, dump_data, cycle_cnt
    );
endinterface

// File: rtl/mips_boot_ctrl.sv
// mips_boot_ctrl: clears memory/registers, loads a program image, releases the core, dumps registers on request
// clk, rst: clock and synchronous active-high reset; bus: mips_boot_ctrl_if master side
module mips_boot_ctrl #(
    parameter int DATA_W   = mips_boot_pkg::DATA_W,
    parameter int ADDR_W   = mips_boot_pkg::ADDR_W,
    parameter int REG_AW   = mips_boot_pkg::REG_AW,
    parameter int HOLD_CYC = mips_boot_pkg::HOLD_CYC,
    parameter int CNT_W    = mips_boot_pkg::CNT_W
) (
    input logic clk,
    input logic rst,
    mips_boot_ctrl_if.master bus
);
    import mips_boot_pkg::*;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int REG_N = 1 << REG_AW;
    localparam int IW    = ADDR_W > REG_AW ? ADDR_W : REG_AW;
    localparam int HW    = $clog2(HOLD_CYC) + 1;
    state_t            state, st;
    logic [IW-1:0]     i, ix;
    logic [REG_AW-1:0] d, dx;
    logic [HW-1:0]     hcnt;
    logic [CNT_W-1:0]  cnt;
    // while rst is high the outputs already show the first CLEAR cycle, so an in-flight beat is dropped
    assign st = rst ? CLEAR : state;
    assign ix = rst ? '0 : i;
    assign dx = rst ? '0 : d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            i     <= '0;
            d     <= '0;
            hcnt  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    i <= i + 1'b1;
                    if (&i) state <= LOAD;
                end
                LOAD: if (bus.ld_valid && bus.ld_last) begin
                    state <= HOLD;
                    hcnt  <= '0;
                end
                HOLD: if (hcnt == HW'(HOLD_CYC - 1)) begin
                    state <= RUN;
                    cnt   <= '0;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (bus.dump_req) begin
                        state <= DUMP;
                        d     <= '0;
                    end
                end
                DUMP: if (bus.dump_ready) begin
                    d <= d + 1'b1;
                    if (&d) state <= RUN;
                end
                default: state <= CLEAR;
            endcase
        end
    end
    assign bus.ld_ready   = st == LOAD;
    assign bus.mem_we     = st == CLEAR ? {1'b0, ix} < (IW + 1)'(DEPTH) : st == LOAD && bus.ld_valid;
    assign bus.mem_addr   = st == CLEAR ? ix[ADDR_W-1:0] : bus.ld_addr;
    assign bus.mem_wdata  = st == CLEAR ? '0 : bus.ld_data;
    assign bus.rf_we      = st == CLEAR && {1'b0, ix} < (IW + 1)'(REG_N);
    assign bus.rf_addr    = st == CLEAR ? ix[REG_AW-1:0] : dx;
    assign bus.rf_wdata   = '0;
    assign bus.cpu_rst    = st inside {CLEAR, LOAD, HOLD};
    assign bus.cpu_stall  = st == DUMP;
    assign bus.dump_valid = st == DUMP;
    assign bus.dump_idx   = dx;
    assign bus.dump_data  = bus.rf_rdata;
    assign bus.cycle_cnt  = rst ? '0 : cnt;
endmodule
